// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing the single-port 8x8 register file among NREQ requesters.
// Define REGARB_LOCK_EN to let a requester hold the grant across accesses (atomic RMW); rw encoding: 1 = Read, 0 = Write.
module regfile_arbiter #(
   parameter int NREQ = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NREQ-1:0]   req_valid_i,
   input  logic [NREQ-1:0]   req_rw_i,
   input  logic [NREQ*3-1:0] req_sel_i,
   input  logic [NREQ*8-1:0] req_wdata_i,
   input  logic [NREQ-1:0]   req_lock_i,
   output logic [NREQ-1:0]   req_ready_o,
   output logic [NREQ-1:0]   rsp_valid_o,
   output logic [7:0]        rsp_data_o,
   output logic              rf_rw_o,
   output logic [2:0]        rf_sel_o,
   output logic [7:0]        rf_in_o,
   input  logic [7:0]        rf_out_i
);

   localparam int   PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic RW_READ = 1'b1;

   logic [PW-1:0]   rrPtr_q, rrPtr_d;
   logic [NREQ-1:0] rdPend_q, rdPend_d;
   logic            grantValid;
   logic [PW-1:0]   grantIdx;
   logic [PW-1:0]   candIdx;
   logic            lockActive;
   logic            holdPtr;
   logic [PW-1:0]   ownerIdx;

`ifdef REGARB_LOCK_EN
   localparam logic ST_UNLOCKED = 1'b0;
   localparam logic ST_LOCKED   = 1'b1;

   logic          state_q, state_d;
   logic [PW-1:0] owner_q, owner_d;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      if (grantValid) begin
         if (state_q == ST_UNLOCKED && req_lock_i[grantIdx]) begin
            state_d = ST_LOCKED;
            owner_d = grantIdx;
         end else if (state_q == ST_LOCKED && !req_lock_i[grantIdx]) begin
            state_d = ST_UNLOCKED;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_UNLOCKED;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   assign lockActive = (state_q == ST_LOCKED);
   assign holdPtr    = (state_q == ST_LOCKED);
   assign ownerIdx   = owner_q;
`else
   logic unusedLock;
   assign unusedLock = ^req_lock_i;
   assign lockActive = 1'b0;
   assign holdPtr    = 1'b0;
   assign ownerIdx   = '0;
`endif

   // While locked only the owner may win; otherwise the first valid requester at or after rrPtr wins.
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      candIdx    = '0;
      if (lockActive) begin
         grantValid = req_valid_i[ownerIdx];
         grantIdx   = ownerIdx;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            candIdx = PW'((int'(rrPtr_q) + k) % NREQ);
            if (!grantValid && req_valid_i[candIdx]) begin
               grantValid = 1'b1;
               grantIdx   = candIdx;
            end
         end
      end
      grantValid = grantValid && !rst_i;
   end

   always_comb begin
      req_ready_o = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready_o[i] = grantValid && (grantIdx == PW'(i));
      end
   end

   // The register file has no enable, so an idle cycle must look like a harmless read of R[0].
   always_comb begin
      rf_rw_o  = RW_READ;
      rf_sel_o = '0;
      rf_in_o  = '0;
      if (grantValid) begin
         rf_rw_o  = req_rw_i[grantIdx];
         rf_sel_o = req_sel_i[int'(grantIdx)*3 +: 3];
         rf_in_o  = req_wdata_i[int'(grantIdx)*8 +: 8];
      end
   end

   always_comb begin
      rrPtr_d  = rrPtr_q;
      rdPend_d = '0;
      if (grantValid && !holdPtr) begin
         rrPtr_d = (grantIdx == PW'(NREQ-1)) ? '0 : grantIdx + PW'(1);
      end
      if (grantValid && rf_rw_o == RW_READ) begin
         rdPend_d = req_ready_o;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rrPtr_q  <= '0;
         rdPend_q <= '0;
      end else begin
         rrPtr_q  <= rrPtr_d;
         rdPend_q <= rdPend_d;
      end
   end

   assign rsp_valid_o = rdPend_q;
   assign rsp_data_o  = rf_out_i;

endmodule
